// File: rtl/disp_scheduler_if.sv
// Handshake and display bus between the cook-control FSM, disp_scheduler and the digit-scan stage.
interface disp_scheduler_if;
  logic       run;
  logic [9:0] time_bin;
  logic [9:0] temp_bin;
  logic       alarm_req;
  logic       alarm_ack;
  logic [3:0] disp_data_7;
  logic [3:0] disp_data_6;
  logic [3:0] disp_data_4;
  logic [1:0] disp_src;

  modport master (
    output run, time_bin, temp_bin, alarm_req,
    input  alarm_ack, disp_data_7, disp_data_6, disp_data_4, disp_src
  );

  modport slave (
    input  run, time_bin, temp_bin, alarm_req,
    output alarm_ack, disp_data_7, disp_data_6, disp_data_4, disp_src
  );
endinterface

// File: rtl/disp_scheduler.sv
// Picks the time/temperature/alarm view for digits 7/6/4 and converts it to BCD by double-dabble.
// Define DISP_LEADING_ZERO_BLANK_EN to blank leading zeros on the hundreds and tens digits.
module disp_scheduler #(
  parameter int unsigned TIME_MS  = 2000,
  parameter int unsigned TEMP_MS  = 1000,
  parameter int unsigned REFRESH  = 100,
  parameter int unsigned BLINK_MS = 250,
  parameter int unsigned ALARM_MS = 3000
) (
  input logic             clk_1Khz,
  input logic             rst,
  disp_scheduler_if.slave bus
);
  localparam int unsigned DWELL_W = $clog2(TIME_MS + TEMP_MS + ALARM_MS + 2);
  localparam int unsigned REF_W   = $clog2(REFRESH + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_MS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_TIME  = 2'b01,
    S_TEMP  = 2'b10,
    S_ALARM = 2'b11
  } state_t;

  state_t             st, st_nxt;
  logic [DWELL_W-1:0] dwell;
  logic [REF_W-1:0]   ref_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_off;
  logic               busy, load_ph;
  logic [3:0]         shift_cnt;
  logic [21:0]        sh, sh_adj;
  logic [3:0]         dig_h, dig_t, dig_u;
  logic               state_chg, tick, start;
  logic [9:0]         src_val, src_sat;
  logic               blank_h, blank_t;

  // Next state and outputs; alarm_req pre-empts every non-alarm state.
  always_comb begin
    st_nxt = st;
    unique case (st)
      S_IDLE:
        if (bus.alarm_req)                          st_nxt = S_ALARM;
        else if (bus.run)                           st_nxt = S_TIME;
      S_TIME:
        if (bus.alarm_req)                          st_nxt = S_ALARM;
        else if (!bus.run)                          st_nxt = S_IDLE;
        else if (dwell == DWELL_W'(TIME_MS - 1))    st_nxt = S_TEMP;
      S_TEMP:
        if (bus.alarm_req)                          st_nxt = S_ALARM;
        else if (!bus.run)                          st_nxt = S_IDLE;
        else if (dwell == DWELL_W'(TEMP_MS - 1))    st_nxt = S_TIME;
      S_ALARM:
        if (dwell == DWELL_W'(ALARM_MS))            st_nxt = S_IDLE;
    endcase

    bus.alarm_ack = (st == S_ALARM) && (dwell == DWELL_W'(ALARM_MS));
    bus.disp_src  = st;
    if (st == S_ALARM) begin
      bus.disp_data_7 = blink_off ? 4'hF : 4'h0;
      bus.disp_data_6 = blink_off ? 4'hF : 4'h0;
      bus.disp_data_4 = blink_off ? 4'hF : 4'h0;
    end else begin
      bus.disp_data_7 = dig_h;
      bus.disp_data_6 = dig_t;
      bus.disp_data_4 = dig_u;
    end
  end

  // Sample control and one double-dabble adjust step.
  always_comb begin
    state_chg = (st_nxt != st);
    tick      = (ref_cnt == REF_W'(REFRESH - 1));
    src_val   = (st_nxt == S_TEMP) ? bus.temp_bin : bus.time_bin;
    src_sat   = (src_val > 10'd999) ? 10'd999 : src_val;
    start     = (st_nxt != S_ALARM) && (state_chg || (tick && !busy));
    sh_adj    = sh;
    for (int unsigned i = 0; i < 3; i++)
      if (sh[10 + 4*i +: 4] >= 4'd5) sh_adj[10 + 4*i +: 4] = sh[10 + 4*i +: 4] + 4'd3;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    blank_h = (sh[21:18] == 4'd0);
    blank_t = blank_h && (sh[17:14] == 4'd0);
`else
    blank_h = 1'b0;
    blank_t = 1'b0;
`endif
  end

  always_ff @(posedge clk_1Khz or negedge rst) begin
    if (!rst) begin
      st        <= S_IDLE;
      dwell     <= '0;
      ref_cnt   <= '0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      st      <= st_nxt;
      dwell   <= state_chg ? '0 : dwell + DWELL_W'(1);
      ref_cnt <= (state_chg || tick) ? '0 : ref_cnt + REF_W'(1);
      if (state_chg) begin
        blink_cnt <= '0;
        blink_off <= 1'b0;
      end else if (st == S_ALARM) begin
        if (blink_cnt == BLINK_W'(BLINK_MS - 1)) begin
          blink_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  // A state change restarts the converter with the new view's value, dropping any pending load.
  always_ff @(posedge clk_1Khz or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      load_ph   <= 1'b0;
      shift_cnt <= '0;
      sh        <= '0;
      dig_h     <= '0;
      dig_t     <= '0;
      dig_u     <= '0;
    end else begin
      if (start) begin
        sh        <= {12'b0, src_sat};
        shift_cnt <= '0;
        busy      <= 1'b1;
        load_ph   <= 1'b0;
      end else if (state_chg) begin
        busy    <= 1'b0;
        load_ph <= 1'b0;
      end else if (busy) begin
        if (load_ph) begin
          dig_h   <= blank_h ? 4'hF : sh[21:18];
          dig_t   <= blank_t ? 4'hF : sh[17:14];
          dig_u   <= sh[13:10];
          busy    <= 1'b0;
          load_ph <= 1'b0;
        end else begin
          sh        <= {sh_adj[20:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt == 4'd9) load_ph <= 1'b1;
        end
      end
      if (st == S_ALARM) begin
        dig_h <= '0;
        dig_t <= '0;
        dig_u <= '0;
      end
    end
  end
endmodule

// File: tb/tb_disp_scheduler.sv
// Bench for disp_scheduler: directed scenarios plus randomized run/value/alarm traffic against a reference model.
module tb_disp_scheduler;
  localparam int TIME_MS  = 2000;
  localparam int TEMP_MS  = 1000;
  localparam int REFRESH  = 100;
  localparam int BLINK_MS = 250;
  localparam int ALARM_MS = 3000;
  localparam int LATENCY  = 11;

  logic clk_1Khz = 1'b0;
  logic rst      = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  disp_scheduler_if bus();

  disp_scheduler #(
    .TIME_MS (TIME_MS),
    .TEMP_MS (TEMP_MS),
    .REFRESH (REFRESH),
    .BLINK_MS(BLINK_MS),
    .ALARM_MS(ALARM_MS)
  ) dut (
    .clk_1Khz(clk_1Khz),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_1Khz = ~clk_1Khz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: view state, cycles since entry, shown value, pending conversion.
  typedef enum int {M_IDLE = 0, M_TIME = 1, M_TEMP = 2, M_ALARM = 3} mst_t;
  mst_t        m_st   = M_IDLE;
  int          m_age  = 0;
  logic [11:0] m_disp = '0;
  bit          m_pend = 1'b0;
  int          m_val  = 0;
  int          m_rem  = 0;

  function automatic int sat(input int v);
    return (v > 999) ? 999 : v;
  endfunction

  function automatic logic [11:0] shown(input int v);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    if (v < 100) h = 15;
    if (v < 10)  t = 15;
`endif
    return {h[3:0], t[3:0], u[3:0]};
  endfunction

  function automatic logic [11:0] exp_digits();
    if (m_st == M_ALARM) return (((m_age / BLINK_MS) % 2) != 0) ? 12'hFFF : 12'h000;
    return m_disp;
  endfunction

  task automatic model_step();
    mst_t nst;
    int   src;
    nst = m_st;
    case (m_st)
      M_IDLE:  nst = bus.alarm_req ? M_ALARM : (bus.run ? M_TIME : M_IDLE);
      M_TIME:  nst = bus.alarm_req ? M_ALARM : (!bus.run ? M_IDLE :
                     ((m_age == TIME_MS - 1) ? M_TEMP : M_TIME));
      M_TEMP:  nst = bus.alarm_req ? M_ALARM : (!bus.run ? M_IDLE :
                     ((m_age == TEMP_MS - 1) ? M_TIME : M_TEMP));
      M_ALARM: nst = (m_age == ALARM_MS) ? M_IDLE : M_ALARM;
      default: nst = M_IDLE;
    endcase
    if (nst != m_st) begin
      m_st   = nst;
      m_age  = 0;
      src    = (nst == M_TEMP) ? int'(bus.temp_bin) : int'(bus.time_bin);
      m_pend = (nst != M_ALARM);
      m_val  = sat(src);
      m_rem  = LATENCY;
    end else begin
      src = (m_st == M_TEMP) ? int'(bus.temp_bin) : int'(bus.time_bin);
      if (m_pend) begin
        m_rem--;
        if (m_rem == 0) begin
          m_disp = shown(m_val);
          m_pend = 1'b0;
        end
      end else if (m_st != M_ALARM && (m_age % REFRESH) == REFRESH - 1) begin
        m_pend = 1'b1;
        m_val  = sat(src);
        m_rem  = LATENCY;
      end
      m_age++;
    end
    if (m_st == M_ALARM) m_disp = '0;
  endtask

  always @(posedge clk_1Khz or negedge rst) begin
    if (!rst) begin
      m_st   = M_IDLE;
      m_age  = 0;
      m_disp = '0;
      m_pend = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk_1Khz) begin
    if (rst) begin
      chk("src", 32'(bus.disp_src), 32'(m_st));
      chk("ack", 32'(bus.alarm_ack), 32'((m_st == M_ALARM) && (m_age == ALARM_MS)));
      chk("digits", 32'({bus.disp_data_7, bus.disp_data_6, bus.disp_data_4}), 32'(exp_digits()));
    end
  end

  function automatic logic [9:0] pick();
    case ($urandom_range(0, 11))
      0:       return 10'd0;
      1:       return 10'd9;
      2:       return 10'd10;
      3:       return 10'd99;
      4:       return 10'd100;
      5:       return 10'd999;
      6:       return 10'd1000;
      7:       return 10'd1023;
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic wait_ack(input string name, output int n);
    n = 0;
    while (!bus.alarm_ack && n < ALARM_MS + 100) begin
      @(negedge clk_1Khz);
      n++;
    end
    chk(name, 32'(bus.alarm_ack), 1);
  endtask

  task automatic do_alarm();
    int n;
    bus.alarm_req = 1'b1;
    wait_ack("rand_ack_seen", n);
    if ($urandom_range(0, 1) == 1) begin
      // held through the IDLE cycle after the ack, so a second alarm follows
      repeat (2) @(negedge clk_1Khz);
      bus.alarm_req = 1'b0;
      wait_ack("rereq_ack_seen", n);
    end
    bus.alarm_req = 1'b0;
  endtask

  function automatic logic [31:0] digs();
    return 32'({bus.disp_data_7, bus.disp_data_6, bus.disp_data_4});
  endfunction

  initial begin
    int n;
    int len;
    bus.run       = 1'b0;
    bus.time_bin  = 10'd345;
    bus.temp_bin  = 10'd0;
    bus.alarm_req = 1'b0;
    repeat (3) @(negedge clk_1Khz);
    rst = 1'b1;

    // IDLE refresh: sample at the 100th edge, digits 11 edges later
    repeat (120) @(negedge clk_1Khz);
    chk("idle_345", digs(), 'h345);
    bus.time_bin = 10'd1023;
    repeat (100) @(negedge clk_1Khz);
    chk("idle_sat_999", digs(), 'h999);

    // asynchronous reset in the middle of a conversion
    bus.time_bin = 10'd345;
    repeat (85) @(negedge clk_1Khz);
    #2 rst = 1'b0;
    #1;
    chk("rst_digits", digs(), 'h000);
    chk("rst_src", 32'(bus.disp_src), 0);
    chk("rst_ack", 32'(bus.alarm_ack), 0);
    @(negedge clk_1Khz);
    rst          = 1'b1;
    bus.run      = 1'b1;
    bus.time_bin = 10'd120;
    bus.temp_bin = 10'd180;

    // rotation: TIME for 2000 cycles, TEMP for 1000, then TIME again
    repeat (1000) @(negedge clk_1Khz);
    chk("time_src", 32'(bus.disp_src), 'h1);
    chk("time_120", digs(), 'h120);
    repeat (1500) @(negedge clk_1Khz);
    chk("temp_src", 32'(bus.disp_src), 'h2);
    chk("temp_180", digs(), 'h180);
    repeat (600) @(negedge clk_1Khz);
    chk("back_time_src", 32'(bus.disp_src), 'h1);
    chk("back_time_120", digs(), 'h120);

    // alarm raised while the TEMP conversion is in flight
    repeat (1905) @(negedge clk_1Khz);
    bus.alarm_req = 1'b1;
    @(negedge clk_1Khz);
    chk("alarm_src", 32'(bus.disp_src), 'h3);
    chk("alarm_on", digs(), 'h000);
    n = 0;
    while (!bus.alarm_ack && n < ALARM_MS + 100) begin
      @(negedge clk_1Khz);
      n++;
      if (n == 300) chk("alarm_blank", digs(), 'hFFF);
    end
    chk("alarm_ack_seen", 32'(bus.alarm_ack), 1);
    chk("alarm_ack_cycle", n, ALARM_MS);
    bus.alarm_req = 1'b0;
    @(negedge clk_1Khz);
    chk("after_ack_idle", 32'(bus.disp_src), 'h0);

    // run dropped mid-TEMP
    n = 0;
    while (bus.disp_src != 2'b10 && n < TIME_MS + 100) begin
      @(negedge clk_1Khz);
      n++;
    end
    chk("reach_temp", 32'(bus.disp_src), 'h2);
    repeat (500) @(negedge clk_1Khz);
    bus.run = 1'b0;
    @(negedge clk_1Khz);
    chk("drop_idle", 32'(bus.disp_src), 'h0);
    repeat (10) @(negedge clk_1Khz);
    chk("drop_hold", digs(), 'h180);
    @(negedge clk_1Khz);
    chk("drop_time", digs(), 'h120);

    // leading-zero handling
    bus.time_bin = 10'd7;
    repeat (115) @(negedge clk_1Khz);
`ifdef DISP_LEADING_ZERO_BLANK_EN
    chk("lead_zero_7", digs(), 'hFF7);
`else
    chk("lead_zero_7", digs(), 'h007);
`endif

    for (int seg = 0; seg < 24; seg++) begin
      if ($urandom_range(0, 5) == 0) begin
        do_alarm();
      end else begin
        bus.run      = 1'($urandom_range(0, 1));
        bus.time_bin = pick();
        bus.temp_bin = pick();
        len = int'($urandom_range(20, 2600));
        for (int k = 0; k < len; k++) begin
          @(negedge clk_1Khz);
          if ($urandom_range(0, 63) == 0)  bus.time_bin = pick();
          if ($urandom_range(0, 63) == 0)  bus.temp_bin = pick();
          if ($urandom_range(0, 799) == 0) bus.run = ~bus.run;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
